// File: rtl/c1_bus_responder_pkg.sv
// Shared bus1 definitions: default widths, C1 command codes and responder states.
package c1_bus_responder_pkg;

    localparam int CACHE_TAG_SIZE_DEF    = 10;
    localparam int CACHE_SET_SIZE_DEF    = 5;
    localparam int CACHE_OFFSET_SIZE_DEF = 4;
    localparam int ADDR1_BUS_SIZE_DEF    = 15;
    localparam int DATA_BUS_SIZE_DEF     = 16;
    localparam int CTR1_BUS_SIZE_DEF     = 3;

    // C1 encodings; RESPONSE shares code 7 with WRITE32 but only the responder drives it
    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_READ8      = 3'd1;
    localparam logic [2:0] CMD_READ16     = 3'd2;
    localparam logic [2:0] CMD_READ32     = 3'd3;
    localparam logic [2:0] CMD_INVALIDATE = 3'd4;
    localparam logic [2:0] CMD_WRITE8     = 3'd5;
    localparam logic [2:0] CMD_WRITE16    = 3'd6;
    localparam logic [2:0] CMD_WRITE32    = 3'd7;
    localparam logic [2:0] CMD_RESPONSE   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR2,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Commands that return data on D1
    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == CMD_READ8) || (cmd == CMD_READ16) || (cmd == CMD_READ32);
    endfunction

endpackage

// File: rtl/c1_bus_responder_tristate.sv
// Registered tri-state driver: holds an output enable and value, floats the bus when disabled.
module c1_tristate_driver #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_drive,
    input  logic         i_release,
    input  logic [W-1:0] i_val,
    inout  wire  [W-1:0] io_bus
);

    logic         r_oe;
    logic [W-1:0] r_val;

    // Release wins over drive so the bus can never be left enabled by a collision
    always_ff @(posedge i_clk) begin
        if (i_rst || i_release) begin
            r_oe  <= 1'b0;
            r_val <= '0;
        end else if (i_drive) begin
            r_oe  <= 1'b1;
            r_val <= i_val;
        end
    end

    assign io_bus = r_oe ? r_val : {W{1'bz}};

endmodule

// File: rtl/c1_bus_responder.sv
// Bus1 responder: collects the two-cycle CPU transfer into one core request and
// serialises the core's result back onto C1/D1 as RESPONSE beats.
module c1_bus_responder
    import c1_bus_responder_pkg::*;
#(
    parameter int CACHE_TAG_SIZE    = CACHE_TAG_SIZE_DEF,
    parameter int CACHE_SET_SIZE    = CACHE_SET_SIZE_DEF,
    parameter int CACHE_OFFSET_SIZE = CACHE_OFFSET_SIZE_DEF,
    parameter int ADDR1_BUS_SIZE    = ADDR1_BUS_SIZE_DEF,
    parameter int DATA_BUS_SIZE     = DATA_BUS_SIZE_DEF,
    parameter int CTR1_BUS_SIZE     = CTR1_BUS_SIZE_DEF
) (
    input  logic                                                        CLK,
    input  logic                                                        RESET,
    inout  wire  [ADDR1_BUS_SIZE-1:0]                                   A1,
    inout  wire  [DATA_BUS_SIZE-1:0]                                    D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]                                    C1,
    output logic                                                        req_valid,
    input  logic                                                        req_ready,
    output logic [CTR1_BUS_SIZE-1:0]                                    req_cmd,
    output logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0] req_addr,
    output logic [31:0]                                                 req_wdata,
    input  logic                                                        resp_valid,
    input  logic [31:0]                                                 resp_rdata,
    output logic                                                        busy
);

    localparam int TS_W = CACHE_TAG_SIZE + CACHE_SET_SIZE;

    state_t                         r_state;
    logic [CTR1_BUS_SIZE-1:0]       r_cmd;
    logic [TS_W-1:0]                r_tagset;
    logic [CACHE_OFFSET_SIZE-1:0]   r_offset;
    logic [31:0]                    r_wdata;
    logic                           r_req_valid;
    logic [15:0]                    r_rdata_hi;
    logic [1:0]                     r_beat_cnt;

    logic                           w_c1_drive;
    logic                           w_d1_drive;
    logic                           w_release;
    logic [DATA_BUS_SIZE-1:0]       w_d1_val;

    // Main request/response sequencer
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_tagset    <= '0;
            r_offset    <= '0;
            r_wdata     <= '0;
            r_req_valid <= 1'b0;
            r_rdata_hi  <= '0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A floating C1 compares unknown here, so only a real command starts a transfer
                    if (C1 != CMD_NOP) begin
                        r_cmd    <= C1;
                        r_tagset <= A1[TS_W-1:0];
                        r_wdata  <= 32'(D1);
                        r_state  <= ST_ADDR2;
                    end
                end
                ST_ADDR2: begin
                    r_offset <= A1[CACHE_OFFSET_SIZE-1:0];
                    case (r_cmd)
                        CMD_WRITE32: r_wdata[31:16] <= D1[15:0];
                        CMD_WRITE16: ;
                        CMD_WRITE8:  r_wdata[15:8]  <= 8'h00;
                        default:     r_wdata        <= '0;
                    endcase
                    r_req_valid <= 1'b1;
                    r_state     <= ST_REQ;
                end
                ST_REQ: begin
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp_valid) begin
                        r_rdata_hi <= resp_rdata[31:16];
                        r_beat_cnt <= (r_cmd == CMD_READ32) ? 2'd2 : 2'd1;
                        r_state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_beat_cnt <= r_beat_cnt - 2'd1;
                    if (r_beat_cnt == 2'd1) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus driver strobes: first beat loads on the WAIT->RESP edge, release on the last beat's edge
    always_comb begin
        w_c1_drive = 1'b0;
        w_d1_drive = 1'b0;
        w_release  = 1'b0;
        w_d1_val   = '0;
        if (r_state == ST_WAIT && resp_valid) begin
            w_c1_drive = 1'b1;
            w_d1_drive = is_read(r_cmd);
            w_d1_val   = (r_cmd == CMD_READ8) ? {8'h00, resp_rdata[7:0]} : resp_rdata[15:0];
        end else if (r_state == ST_RESP) begin
            if (r_beat_cnt == 2'd1) begin
                w_release = 1'b1;
            end else begin
                // Only READ32 reaches here: second beat carries the upper half
                w_d1_drive = 1'b1;
                w_d1_val   = r_rdata_hi;
            end
        end
    end

    c1_tristate_driver #(.W(CTR1_BUS_SIZE)) u_c1_drv (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_drive   (w_c1_drive),
        .i_release (w_release),
        .i_val     (CTR1_BUS_SIZE'(CMD_RESPONSE)),
        .io_bus    (C1)
    );

    c1_tristate_driver #(.W(DATA_BUS_SIZE)) u_d1_drv (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_drive   (w_d1_drive),
        .i_release (w_release),
        .i_val     (w_d1_val),
        .io_bus    (D1)
    );

    assign req_valid = r_req_valid;
    assign req_cmd   = r_cmd;
    assign req_addr  = {r_tagset, r_offset};
    assign req_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_c1_bus_responder.sv
// Randomised bench for c1_bus_responder: CPU-side bus driver, core model and
// a transaction-level expectation derived from the command rules.
module tb_c1_bus_responder;
  import c1_bus_responder_pkg::*;

  localparam int TW = 10, SW = 5, OW = 4, AW = 15, DW = 16, CW = 3;
  localparam int RAW = TW + SW + OW;
  localparam logic [DW-1:0] ZD = {DW{1'bz}};
  localparam logic [CW-1:0] ZC = {CW{1'bz}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire  [AW-1:0] A1;
  wire  [DW-1:0] D1;
  wire  [CW-1:0] C1;
  logic [AW-1:0] a1_q = '0;
  logic [DW-1:0] d1_q = '0;
  logic [CW-1:0] c1_q = '0;
  logic          cpu_oe = 1'b0;

  assign A1 = cpu_oe ? a1_q : {AW{1'bz}};
  assign D1 = cpu_oe ? d1_q : {DW{1'bz}};
  assign C1 = cpu_oe ? c1_q : {CW{1'bz}};

  logic           req_valid;
  logic           req_ready = 1'b0;
  logic [CW-1:0]  req_cmd;
  logic [RAW-1:0] req_addr;
  logic [31:0]    req_wdata;
  logic           resp_valid = 1'b0;
  logic [31:0]    resp_rdata = '0;
  logic           busy;

  c1_bus_responder dut (
    .CLK        (clk),
    .RESET      (rst),
    .A1         (A1),
    .D1         (D1),
    .C1         (C1),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected write payload from the two D1 words
  function automatic logic [31:0] exp_wdata(input logic [2:0] cmd, input logic [15:0] lo, input logic [15:0] hi);
    case (cmd)
      CMD_WRITE32: return {hi, lo};
      CMD_WRITE16: return {16'h0, lo};
      CMD_WRITE8:  return {24'h0, lo[7:0]};
      default:     return 32'h0;
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, ".c1z"}, 32'(C1), 32'(ZC));
    chk({tag, ".d1z"}, 32'(D1), 32'(ZD));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".rv"}, 32'(req_valid), 32'd0);
  endtask

  task automatic run_txn(input logic [2:0] cmd, input logic [9:0] tag, input logic [4:0] set,
                         input logic [3:0] off, input logic [15:0] lo, input logic [15:0] hi,
                         input int stall, input int rdly, input logic [31:0] rd,
                         input bit spur, input bit rst_mid);
    logic [RAW-1:0] e_addr;
    logic [31:0]    e_wd;
    logic [15:0]    beats[$];
    e_addr = {tag, set, off};
    e_wd   = exp_wdata(cmd, lo, hi);
    beats  = {};
    case (cmd)
      CMD_READ32: begin beats.push_back(rd[15:0]); beats.push_back(rd[31:16]); end
      CMD_READ16: beats.push_back(rd[15:0]);
      CMD_READ8:  beats.push_back({8'h00, rd[7:0]});
      default:    beats.push_back(ZD);
    endcase

    // Two-cycle CPU transfer, then release the bus
    @(posedge clk); #1;
    c1_q = cmd; a1_q = {tag, set}; d1_q = lo; cpu_oe = 1'b1;
    @(posedge clk); #1;
    a1_q = {11'($urandom), off}; d1_q = hi;
    @(posedge clk); #1;
    cpu_oe = 1'b0;

    @(negedge clk);
    chk("req.valid", 32'(req_valid), 32'd1);
    chk("req.cmd", 32'(req_cmd), 32'(cmd));
    chk("req.addr", 32'(req_addr), 32'(e_addr));
    chk("req.wdata", req_wdata, e_wd);
    chk("req.busy", 32'(busy), 32'd1);
    chk("req.c1z", 32'(C1), 32'(ZC));
    chk("req.d1z", 32'(D1), 32'(ZD));
    for (int i = 0; i < stall; i++) begin
      if (spur && i == 0) begin resp_valid = 1'b1; resp_rdata = ~rd; end
      @(posedge clk); #1;
      resp_valid = 1'b0;
      @(negedge clk);
      chk("stall.valid", 32'(req_valid), 32'd1);
      chk("stall.addr", 32'(req_addr), 32'(e_addr));
      chk("stall.wdata", req_wdata, e_wd);
      chk("stall.cmd", 32'(req_cmd), 32'(cmd));
    end
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    chk("acc.valid", 32'(req_valid), 32'd0);
    chk("acc.c1z", 32'(C1), 32'(ZC));

    // Core result after rdly idle cycles, single-cycle pulse
    repeat (rdly) @(negedge clk);
    resp_valid = 1'b1; resp_rdata = rd;
    @(posedge clk); #1;
    resp_valid = 1'b0; resp_rdata = $urandom;

    for (int i = 0; i < beats.size(); i++) begin
      @(negedge clk);
      chk("beat.c1", 32'(C1), 32'(CMD_RESPONSE));
      chk("beat.d1", 32'(D1), 32'(beats[i]));
      chk("beat.busy", 32'(busy), 32'd1);
      if (rst_mid && i == 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle("midrst");
        chk("midrst.cmd", 32'(req_cmd), 32'd0);
        chk("midrst.addr", 32'(req_addr), 32'd0);
        chk("midrst.wdata", req_wdata, 32'd0);
        return;
      end
      @(posedge clk);
    end
    chk_idle("done");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("rst");
    chk("rst.cmd", 32'(req_cmd), 32'd0);
    chk("rst.addr", 32'(req_addr), 32'd0);
    chk("rst.wdata", req_wdata, 32'd0);

    run_txn(CMD_WRITE32, 10'd1, 5'd2, 4'd3, 16'h1234, 16'hABCD, 0, 0, 32'h0BADF00D, 0, 0);
    run_txn(CMD_READ32,  10'd1, 5'd2, 4'd3, 16'h5555, 16'h6666, 0, 0, 32'hDEADBEEF, 0, 0);
    run_txn(CMD_READ8,   10'd7, 5'd9, 4'd1, 16'hFFFF, 16'hEEEE, 0, 1, 32'h123456A5, 0, 0);
    run_txn(CMD_READ16,  10'd7, 5'd9, 4'd1, 16'hFFFF, 16'hEEEE, 0, 1, 32'h123456A5, 0, 0);
    run_txn(CMD_INVALIDATE, 10'd0, 5'd2, 4'd3, 16'hA5A5, 16'h5A5A, 0, 0, 32'hFFFFFFFF, 0, 0);
    run_txn(CMD_WRITE8,  10'h3FF, 5'h1F, 4'hF, 16'hBEEF, 16'hCAFE, 3, 2, 32'h11111111, 1, 0);
    run_txn(CMD_READ32,  10'h155, 5'h0A, 4'h5, 16'h0000, 16'h0000, 1, 0, 32'hCAFEF00D, 0, 1);
    run_txn(CMD_WRITE16, 10'h2AA, 5'h15, 4'hA, 16'h8001, 16'h7FFE, 0, 0, 32'h0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      logic [2:0] c;
      c = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) begin
        // Stray core result while idle must be ignored
        @(negedge clk); resp_valid = 1'b1; resp_rdata = $urandom;
        @(posedge clk); #1; resp_valid = 1'b0;
        chk_idle("stray");
      end
      run_txn(c, 10'($urandom), 5'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
